// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the memory responder.
// Source tags, latency bounds and the address range check.
package mem_resp_pkg;

    // Origin of a read travelling down the latency pipe.
    typedef enum logic {
        SRC_ENG  = 1'b0,
        SRC_HOST = 1'b1
    } src_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // True when any address bit at or above depth_log2 is set.
    function automatic logic addr_oor(
        input logic [63:0] addr,
        input int unsigned depth_log2
    );
        return (addr >> depth_log2) != 64'd0;
    endfunction

endpackage

// File: rtl/mem_responder_rd_lat_pipe.sv
// Fixed-latency read return pipe.
// Carries {valid, src, data}; only the valid chain is reset.
module rd_lat_pipe
    import mem_resp_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int MEM_DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  src_t              in_src,
    input  logic [MEM_DW-1:0] in_data,
    output logic              out_vld,
    output src_t              out_src,
    output logic [MEM_DW-1:0] out_data
);

    logic [RD_LAT-1:0] vld_q;
    src_t              src_q  [RD_LAT];
    logic [MEM_DW-1:0] data_q [RD_LAT];

    // Valid chain: cleared on reset so no return survives it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_vld;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Payload stages follow the valid chain without reset.
    always_ff @(posedge clk) begin
        src_q[0]  <= in_src;
        data_q[0] <= in_data;
        for (int i = 1; i < RD_LAT; i++) begin
            src_q[i]  <= src_q[i-1];
            data_q[i] <= data_q[i-1];
        end
    end

    assign out_vld  = vld_q[RD_LAT-1];
    assign out_src  = src_q[RD_LAT-1];
    assign out_data = data_q[RD_LAT-1];

endmodule

// File: rtl/mem_responder.sv
// Word-addressed SRAM target for an engine plus a low-priority host port.
// Fixed read latency, engine never stalled, sticky out-of-range flag.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int MEM_AW     = 16,
    parameter int MEM_DW     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LAT     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              mem_write,
    input  logic [MEM_AW-1:0] mem_addr,
    input  logic [MEM_DW-1:0] mem_wdata,
    output logic              mem_rdata_vld,
    output logic [MEM_DW-1:0] mem_rdata,
    input  logic              host_req,
    input  logic              host_write,
    input  logic [MEM_AW-1:0] host_addr,
    input  logic [MEM_DW-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rdata_vld,
    output logic [MEM_DW-1:0] host_rdata,
    output logic              err_oor,
    input  logic              err_clr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX ||
        DEPTH_LOG2 > MEM_AW) begin : g_param_err
        $error("mem_responder: illegal RD_LAT or DEPTH_LOG2");
    end

    logic [MEM_DW-1:0] store [DEPTH];

    logic                  acc_vld;
    logic                  acc_write;
    logic [MEM_AW-1:0]     acc_addr;
    logic [MEM_DW-1:0]     acc_wdata;
    src_t                  acc_src;
    logic                  acc_oor;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic [MEM_DW-1:0]     rd_word;

    logic              ret_vld;
    src_t              ret_src;
    logic [MEM_DW-1:0] ret_data;
    logic              eng_ret;
    logic              host_ret;
    logic [MEM_DW-1:0] eng_hold;
    logic [MEM_DW-1:0] host_hold;

    // Engine wins every cycle it requests; host takes the gaps.
    always_comb begin
        host_gnt  = host_req & ~mem_req;
        acc_vld   = mem_req | host_gnt;
        acc_write = mem_write;
        acc_addr  = mem_addr;
        acc_wdata = mem_wdata;
        acc_src   = SRC_ENG;
        if (!mem_req) begin
            acc_write = host_write;
            acc_addr  = host_addr;
            acc_wdata = host_wdata;
            acc_src   = SRC_HOST;
        end
    end

    assign acc_oor = addr_oor(64'(acc_addr), DEPTH_LOG2);
    assign acc_idx = acc_addr[DEPTH_LOG2-1:0];
    assign rd_word = acc_oor ? '0 : store[acc_idx];

    // Storage write port; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (!rst && acc_vld && acc_write && !acc_oor) begin
            store[acc_idx] <= acc_wdata;
        end
    end

    rd_lat_pipe #(
        .RD_LAT (RD_LAT),
        .MEM_DW (MEM_DW)
    ) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (acc_vld & ~acc_write),
        .in_src   (acc_src),
        .in_data  (rd_word),
        .out_vld  (ret_vld),
        .out_src  (ret_src),
        .out_data (ret_data)
    );

    assign eng_ret  = ret_vld && (ret_src == SRC_ENG);
    assign host_ret = ret_vld && (ret_src == SRC_HOST);

    // Remember the last returned word per port for idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_hold  <= '0;
            host_hold <= '0;
        end else begin
            if (eng_ret) begin
                eng_hold <= ret_data;
            end
            if (host_ret) begin
                host_hold <= ret_data;
            end
        end
    end

    assign mem_rdata_vld  = eng_ret;
    assign mem_rdata      = eng_ret ? ret_data : eng_hold;
    assign host_rdata_vld = host_ret;
    assign host_rdata     = host_ret ? ret_data : host_hold;

    // Sticky range error; a new violation beats a same-edge clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_oor <= 1'b0;
        end else if (acc_vld && acc_oor) begin
            err_oor <= 1'b1;
        end else if (err_clr) begin
            err_oor <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (RD_LAT 2, 1, 4) on shared stimulus.
// A cycle-level memory model predicts every output each cycle.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_write = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        host_req = 1'b0;
    logic        host_write = 1'b0;
    logic [15:0] host_addr = '0;
    logic [31:0] host_wdata = '0;
    logic        err_clr = 1'b0;

    logic        mvld  [3];
    logic [31:0] mdata [3];
    logic        hgnt  [3];
    logic        hvld  [3];
    logic [31:0] hdata [3];
    logic        err   [3];

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;
    int np [3] = '{0, 0, 0};
    int nh [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    function automatic int lat_of(int g);
        return (g == 0) ? 2 : (g == 1) ? 1 : 4;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 4;
        mem_responder #(
            .MEM_AW(16), .MEM_DW(32), .DEPTH_LOG2(10), .RD_LAT(L)
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .mem_req        (mem_req),
            .mem_write      (mem_write),
            .mem_addr       (mem_addr),
            .mem_wdata      (mem_wdata),
            .mem_rdata_vld  (mvld[g]),
            .mem_rdata      (mdata[g]),
            .host_req       (host_req),
            .host_write     (host_write),
            .host_addr      (host_addr),
            .host_wdata     (host_wdata),
            .host_gnt       (hgnt[g]),
            .host_rdata_vld (hvld[g]),
            .host_rdata     (hdata[g]),
            .err_oor        (err[g]),
            .err_clr        (err_clr)
        );
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mdl_mem [1024];
    bit          sch_vld  [3][64];
    bit          sch_host [3][64];
    logic [31:0] sch_data [3][64];
    bit          e_mvld [3];
    bit          e_hvld [3];
    logic [31:0] e_mdata [3];
    logic [31:0] e_hdata [3];
    bit          e_err = 0;
    int unsigned cyc = 0;

    initial begin
        for (int g = 0; g < 3; g++) begin
            e_mvld[g] = 0; e_hvld[g] = 0;
            e_mdata[g] = '0; e_hdata[g] = '0;
            for (int s = 0; s < 64; s++) sch_vld[g][s] = 0;
        end
    end

    always @(posedge clk) begin
        bit          acc, wr, hsel, oor;
        logic [15:0] a;
        logic [31:0] wd, rd;
        int          slot;
        cyc++;
        if (rst) begin
            e_err = 0;
            for (int g = 0; g < 3; g++) begin
                e_mvld[g] = 0; e_hvld[g] = 0;
                e_mdata[g] = '0; e_hdata[g] = '0;
                for (int s = 0; s < 64; s++) sch_vld[g][s] = 0;
            end
        end else begin
            hsel = !mem_req && host_req;
            acc  = mem_req || host_req;
            wr   = hsel ? host_write : mem_write;
            a    = hsel ? host_addr : mem_addr;
            wd   = hsel ? host_wdata : mem_wdata;
            oor  = a >= 16'd1024;
            rd   = oor ? 32'd0 : mdl_mem[a[9:0]];
            if (acc && !wr) begin
                for (int g = 0; g < 3; g++) begin
                    slot = int'((cyc + lat_of(g) - 1) % 64);
                    sch_vld[g][slot]  = 1;
                    sch_host[g][slot] = hsel;
                    sch_data[g][slot] = rd;
                end
            end
            if (acc && wr && !oor) mdl_mem[a[9:0]] = wd;
            for (int g = 0; g < 3; g++) begin
                slot = int'(cyc % 64);
                e_mvld[g] = 0;
                e_hvld[g] = 0;
                if (sch_vld[g][slot]) begin
                    if (sch_host[g][slot]) begin
                        e_hvld[g] = 1; e_hdata[g] = sch_data[g][slot];
                    end else begin
                        e_mvld[g] = 1; e_mdata[g] = sch_data[g][slot];
                    end
                    sch_vld[g][slot] = 0;
                end
            end
            if (acc && oor) e_err = 1;
            else if (err_clr) e_err = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            for (int g = 0; g < 3; g++) begin
                chk($sformatf("mem_vld[L%0d]", lat_of(g)), 32'(mvld[g]),
                    rst ? 32'd0 : 32'(e_mvld[g]));
                chk($sformatf("mem_rdata[L%0d]", lat_of(g)), mdata[g],
                    rst ? 32'd0 : e_mdata[g]);
                chk($sformatf("host_vld[L%0d]", lat_of(g)), 32'(hvld[g]),
                    rst ? 32'd0 : 32'(e_hvld[g]));
                chk($sformatf("host_rdata[L%0d]", lat_of(g)), hdata[g],
                    rst ? 32'd0 : e_hdata[g]);
                chk($sformatf("err_oor[L%0d]", lat_of(g)), 32'(err[g]),
                    rst ? 32'd0 : 32'(e_err));
                chk($sformatf("host_gnt[L%0d]", lat_of(g)), 32'(hgnt[g]),
                    32'(host_req & ~mem_req));
            end
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (mvld[g] === 1'b1) np[g]++;
            if (hvld[g] === 1'b1) nh[g]++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    task automatic eng(bit w, logic [15:0] a, logic [31:0] d);
        mem_req = 1; mem_write = w; mem_addr = a; mem_wdata = d;
        tick();
        mem_req = 0; mem_write = 0;
    endtask

    task automatic host(bit w, logic [15:0] a, logic [31:0] d);
        bit got = 0;
        host_req = 1; host_write = w; host_addr = a; host_wdata = d;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            got = hgnt[0];
        end
        #1;
        host_req = 0; host_write = 0;
        if (!got) chk("host_gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic all_mdata(string nm, logic [31:0] exp);
        for (int g = 0; g < 3; g++)
            chk($sformatf("%s[L%0d]", nm, lat_of(g)), mdata[g], exp);
    endtask

    task automatic all_err(string nm, bit exp);
        for (int g = 0; g < 3; g++)
            chk($sformatf("%s[L%0d]", nm, lat_of(g)), 32'(err[g]), 32'(exp));
    endtask

    int np0 [3];
    int nh0 [3];

    task automatic snap();
        for (int g = 0; g < 3; g++) begin
            np0[g] = np[g]; nh0[g] = nh[g];
        end
    endtask

    task automatic pulses(string nm, int ne, int nhst);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s_eng_pulses[L%0d]", nm, lat_of(g)),
                32'(np[g] - np0[g]), 32'(ne));
            chk($sformatf("%s_host_pulses[L%0d]", nm, lat_of(g)),
                32'(nh[g] - nh0[g]), 32'(nhst));
        end
    endtask

    initial begin
        #1 rst = 1;
        #1 chk_en = 1;
        idle(3);
        @(negedge clk);
        all_mdata("reset_mdata", 32'd0);
        all_err("reset_err", 1'b0);
        @(posedge clk);
        #1 rst = 0;

        // Host preload 0x11..0x88 into words 0..7
        for (int i = 0; i < 8; i++) host(1, 16'(i), 32'h11 * (i + 1));

        // Engine streams reads 0,1,2
        snap();
        eng(0, 16'd0, 0); eng(0, 16'd1, 0); eng(0, 16'd2, 0);
        idle(6);
        pulses("rd012", 3, 0);
        all_mdata("rd012_last", 32'h33);

        // Engine write then read-after-write
        snap();
        eng(1, 16'd5, 32'hDEAD_BEEF);
        eng(0, 16'd5, 0);
        idle(6);
        pulses("raw", 1, 0);
        all_mdata("raw_data", 32'hDEAD_BEEF);

        // Host read blocked by 4 engine reads
        snap();
        mem_req = 1; mem_write = 0; mem_addr = 16'd0;
        host_req = 1; host_write = 0; host_addr = 16'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("gnt_blocked", 32'(hgnt[0]), 32'd0);
            tick();
        end
        mem_req = 0;
        @(negedge clk);
        chk("gnt_free", 32'(hgnt[0]), 32'd1);
        tick();
        host_req = 0;
        idle(6);
        pulses("arb", 4, 1);
        for (int g = 0; g < 3; g++)
            chk($sformatf("arb_hdata[L%0d]", lat_of(g)), hdata[g], 32'h22);
        all_mdata("arb_mdata", 32'h11);

        // Out-of-range read, dropped write, sticky flag and clear
        snap();
        eng(0, 16'h0400, 0);
        idle(6);
        pulses("oor_rd", 1, 0);
        all_mdata("oor_rdata", 32'd0);
        all_err("oor_set", 1'b1);
        eng(1, 16'h0400, 32'hBAD0_BAD0);
        eng(0, 16'h0000, 0);
        idle(6);
        all_mdata("oor_wr_dropped", 32'h11);
        all_err("oor_sticky", 1'b1);
        err_clr = 1;
        tick();
        err_clr = 0;
        @(negedge clk);
        all_err("oor_cleared", 1'b0);
        err_clr = 1;
        eng(0, 16'h8000, 0);
        err_clr = 0;
        @(negedge clk);
        all_err("oor_set_wins", 1'b1);
        err_clr = 1;
        tick();
        err_clr = 0;
        idle(6);

        // Reset while a read is in flight
        snap();
        eng(0, 16'd2, 0);
        rst = 1;
        @(negedge clk);
        for (int g = 0; g < 3; g++)
            chk($sformatf("rst_vld[L%0d]", lat_of(g)), 32'(mvld[g]), 32'd0);
        all_mdata("rst_mdata", 32'd0);
        all_err("rst_err", 1'b0);
        tick();
        rst = 0;
        idle(6);
        pulses("rst_flush", 0, 0);

        // Stream 8 reads on every latency
        snap();
        for (int i = 0; i < 8; i++) eng(0, 16'(i), 0);
        idle(7);
        pulses("stream8", 8, 0);
        all_mdata("stream8_last", 32'h88);

        @(negedge clk);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
